// File: rtl/alu_ctrl_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_issue
// Purpose  : ALU issue stage. Decodes ALUOp/funct3/funct7[5] into a 4-bit
//            control code and queues it with its operands in a small in-order
//            FIFO. The optional ALU_CTRL_ISSUE_PERF_EN adds saturating
//            issue/illegal counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_issue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [3:0]        alu_control_signal,
`ifdef ALU_CTRL_ISSUE_PERF_EN
  output logic [31:0]       issue_count,
  output logic [15:0]       illegal_count,
`endif
  output logic              out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] a_mem_q   [DEPTH];
  logic [DATA_W-1:0] b_mem_q   [DEPTH];
  logic [3:0]        code_mem_q[DEPTH];
  logic              ill_mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop;
  logic [3:0]        dec_code;
  logic              dec_illegal;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = !reset && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_a              = a_mem_q[rd_ptr_q];
  assign out_b              = b_mem_q[rd_ptr_q];
  assign alu_control_signal = code_mem_q[rd_ptr_q];
  assign out_illegal        = ill_mem_q[rd_ptr_q];

  always_comb begin
    dec_code    = 4'b1111;
    dec_illegal = 1'b1;
    unique case (in_alu_op)
      2'b00: begin dec_code = 4'b0000; dec_illegal = 1'b0; end
      2'b01: begin dec_code = 4'b1000; dec_illegal = 1'b0; end
      default: begin
        // funct7[5] selects sub only for register-register ops.
        case (in_funct3)
          3'b000: begin
            dec_code    = (in_alu_op == 2'b10 && in_funct7_5) ? 4'b1000 : 4'b0000;
            dec_illegal = 1'b0;
          end
          3'b100: begin dec_code = 4'b0100; dec_illegal = 1'b0; end
          3'b110: begin dec_code = 4'b0110; dec_illegal = 1'b0; end
          3'b111: begin dec_code = 4'b0111; dec_illegal = 1'b0; end
          default: begin dec_code = 4'b1111; dec_illegal = 1'b1; end
        endcase
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_q[i]    <= '0;
        b_mem_q[i]    <= '0;
        code_mem_q[i] <= '0;
        ill_mem_q[i]  <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        a_mem_q[wr_ptr_q]    <= in_a;
        b_mem_q[wr_ptr_q]    <= in_b;
        code_mem_q[wr_ptr_q] <= dec_code;
        ill_mem_q[wr_ptr_q]  <= dec_illegal;
      end
    end
  end

`ifdef ALU_CTRL_ISSUE_PERF_EN
  logic [31:0] issue_cnt_q;
  logic [15:0] illegal_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (pop && issue_cnt_q != '1) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (pop && out_illegal && illegal_cnt_q != '1) begin
        illegal_cnt_q <= illegal_cnt_q + 16'd1;
      end
    end
  end

  assign issue_count   = issue_cnt_q;
  assign illegal_count = illegal_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_issue
// Purpose  : Scoreboard bench for alu_ctrl_issue (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [63:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a, out_b;
  logic [3:0]  alu_control_signal;
  logic        out_illegal;
`ifdef ALU_CTRL_ISSUE_PERF_EN
  logic [31:0] issue_count;
  logic [15:0] illegal_count;
`endif

  alu_ctrl_issue #(.DATA_W(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .alu_control_signal(alu_control_signal),
`ifdef ALU_CTRL_ISSUE_PERF_EN
    .issue_count(issue_count), .illegal_count(illegal_count),
`endif
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  code;
    logic        ill;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t exp_of(input logic [1:0] op, input logic [2:0] f3,
                                  input logic f7, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.a = a; e.b = b; e.ill = 1'b0;
    if (op == 2'b00)      e.code = 4'b0000;
    else if (op == 2'b01) e.code = 4'b1000;
    else if (f3 == 3'b000) e.code = (op == 2'b10 && f7) ? 4'b1000 : 4'b0000;
    else if (f3 == 3'b100) e.code = 4'b0100;
    else if (f3 == 3'b110) e.code = 4'b0110;
    else if (f3 == 3'b111) e.code = 4'b0111;
    else begin e.code = 4'b1111; e.ill = 1'b1; end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1; in_alu_op = op; in_funct3 = f3; in_funct7_5 = f7; in_a = a; in_b = b;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_alu_op = 2'b10; in_funct3 = 3'b000; in_funct7_5 = 1'b0; in_a = '0; in_b = '0;
    tick; tick;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_illegal !== 1'b0 ||
        alu_control_signal !== 4'b0000 || out_a !== 64'd0 || out_b !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b ill=%b code=%b a=%h b=%h, need 0 0 0 0000 0 0",
               in_ready, out_valid, out_illegal, alu_control_signal, out_a, out_b);
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single;
    exp_t e;
    out_ready = 1'b1;
    set_in(2'b10, 3'b000, 1'b1, 64'd10, 64'd3);
    if (in_valid && in_ready) sb.push_back(exp_of(2'b10, 3'b000, 1'b1, 64'd10, 64'd3));
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sb.size() != 1) begin
      errors++;
      $display("FAIL single_latency: out_valid=%b queued=%0d, need 1 1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({alu_control_signal, out_illegal, out_a, out_b} !== {e.code, e.ill, e.a, e.b}) begin
        errors++;
        $display("FAIL single_head: code=%b ill=%b a=%0d b=%0d, need code=%b ill=%b a=%0d b=%0d",
                 alu_control_signal, out_illegal, out_a, out_b, e.code, e.ill, e.a, e.b);
      end
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: out_valid=%b, need 0", out_valid);
    end
  endtask

  // Offers ops[] in order under a fixed out_ready pattern and scoreboards every pop.
  task automatic run_stream(input string name, input logic [1:0] ops[],
                            input logic [2:0] f3s[], input logic f7s[], input int stall_cycles);
    exp_t e;
    int n = 0;
    int cyc = 0;
    while ((n < ops.size() || sb.size() != 0) && cyc < 40) begin
      out_ready = (cyc >= stall_cycles);
      if (n < ops.size()) set_in(ops[n], f3s[n], f7s[n], 64'(100 + n), 64'(200 + n));
      else in_valid = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_pop: code=%b, nothing expected", name, alu_control_signal);
        end else begin
          e = sb.pop_front();
          if ({alu_control_signal, out_illegal, out_a, out_b} !== {e.code, e.ill, e.a, e.b}) begin
            errors++;
            $display("FAIL %s_head: code=%b ill=%b a=%0d b=%0d, need code=%b ill=%b a=%0d b=%0d",
                     name, alu_control_signal, out_illegal, out_a, out_b, e.code, e.ill, e.a, e.b);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(exp_of(ops[n], f3s[n], f7s[n], 64'(100 + n), 64'(200 + n)));
        n++;
      end
      if (cyc == stall_cycles - 1) begin
        checks++;
        if (in_ready !== 1'b0 || n != 2) begin
          errors++;
          $display("FAIL %s_full: in_ready=%b accepted=%0d, need 0 2", name, in_ready, n);
        end
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (sb.size() != 0 || n != ops.size() || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: left=%0d accepted=%0d out_valid=%b, need 0 %0d 0",
               name, sb.size(), n, out_valid, ops.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ops[] = '{2'b10, 2'b11, 2'b10};
    logic [2:0] f3s[] = '{3'b100, 3'b110, 3'b111};
    logic       f7s[] = '{1'b0, 1'b1, 1'b0};
    run_stream("b2b", ops, f3s, f7s, 4);
  endtask

  task automatic test_illegal;
    logic [1:0] ops[] = '{2'b10, 2'b10, 2'b11};
    logic [2:0] f3s[] = '{3'b000, 3'b001, 3'b000};
    logic       f7s[] = '{1'b0, 1'b0, 1'b1};
    run_stream("illegal", ops, f3s, f7s, 0);
  endtask

  task automatic test_full_hold;
    exp_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(2'b00, 3'b000, 1'b0, 64'(i + 1), 64'd7);
      if (in_ready) sb.push_back(exp_of(2'b00, 3'b000, 1'b0, 64'(i + 1), 64'd7));
      tick;
    end
    set_in(2'b01, 3'b000, 1'b0, 64'd3, 64'd7);
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || sb.size() != 2) begin
      errors++;
      $display("FAIL full_state: in_ready=%b out_valid=%b queued=%0d, need 0 1 2", in_ready, out_valid, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (out_a !== e.a || alu_control_signal !== e.code) begin
        errors++;
        $display("FAIL full_pop1: a=%0d code=%b, need a=%0d code=%b", out_a, alu_control_signal, e.a, e.code);
      end
    end
    tick;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reopen: in_ready=%b, need 1", in_ready);
    end
    sb.push_back(exp_of(2'b01, 3'b000, 1'b0, 64'd3, 64'd7));
    tick;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_a !== 64'd2) begin
      errors++;
      $display("FAIL full_refill: in_ready=%b head_a=%0d, need 0 2", in_ready, out_a);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4 && sb.size() != 0; c++) begin
      if (out_valid) begin
        e = sb.pop_front();
        checks++;
        if ({alu_control_signal, out_illegal, out_a, out_b} !== {e.code, e.ill, e.a, e.b}) begin
          errors++;
          $display("FAIL full_drain_head: code=%b a=%0d, need code=%b a=%0d", alu_control_signal, out_a, e.code, e.a);
        end
      end
      tick;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_once: left=%0d out_valid=%b, need 0 0", sb.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    exp_t e;
    logic [1:0] op; logic [2:0] f3; logic f7; logic [63:0] a, b;
    for (int c = 0; c < 80; c++) begin
      if (!in_valid || in_ready || c == 0) begin
        op = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7)); f7 = 1'($urandom_range(0, 1));
        a = {32'($urandom), 32'($urandom)}; b = {32'($urandom), 32'($urandom)};
      end
      set_in(op, f3, f7, a, b);
      in_valid  = (c < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 70) ? 1'($urandom_range(0, 1)) : 1'b1;
      checks++;
      if (out_valid !== (sb.size() != 0) || in_ready !== (sb.size() < 2)) begin
        errors++;
        $display("FAIL rand_flags: out_valid=%b in_ready=%b, need %b %b",
                 out_valid, in_ready, sb.size() != 0, sb.size() < 2);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({alu_control_signal, out_illegal, out_a, out_b} !== {e.code, e.ill, e.a, e.b}) begin
          errors++;
          $display("FAIL rand_head: code=%b ill=%b a=%h b=%h, need code=%b ill=%b a=%h b=%h",
                   alu_control_signal, out_illegal, out_a, out_b, e.code, e.ill, e.a, e.b);
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_of(op, f3, f7, a, b));
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: left=%0d out_valid=%b, need 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(2'b11, 3'b111, 1'b0, 64'(50 + i), 64'd1);
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_prefill: out_valid=%b in_ready=%b, need 1 0", out_valid, in_ready);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_a !== 64'd0 || alu_control_signal !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b a=%0d code=%b, need 0 1 0 0000",
               out_valid, in_ready, out_a, alu_control_signal);
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_issue: out_valid=%b, need 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

`ifdef ALU_CTRL_ISSUE_PERF_EN
  task automatic test_perf;
    logic [1:0] ops[] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b10};
    logic [2:0] f3s[] = '{3'b000, 3'b010, 3'b100, 3'b000, 3'b111};
    logic       f7s[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (issue_count !== 32'd0 || illegal_count !== 16'd0) begin
      errors++;
      $display("FAIL perf_clear: issue=%0d illegal=%0d, need 0 0", issue_count, illegal_count);
    end
    run_stream("perf", ops, f3s, f7s, 0);
    checks++;
    if (issue_count !== 32'd5 || illegal_count !== 16'd1) begin
      errors++;
      $display("FAIL perf_counts: issue=%0d illegal=%0d, need 5 1", issue_count, illegal_count);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_illegal;
    test_full_hold;
    test_random;
    test_reset_mid;
`ifdef ALU_CTRL_ISSUE_PERF_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
Issue stage in front of the 64-bit ALU. It accepts decoded-instruction fields and operands over a valid/ready handshake, and translates ALUOp/funct3/funct7[5] into the 4-bit alu_control_signal the ALU consumes. A 2-entry in-order skid FIFO decouples decode from execute, so an execute-side stall never drops or reorders an operation.

Parameters:
- DATA_W, 64, operand width; must match the ALU.
- DEPTH, 2, FIFO entries; legal values are 2 and 4 (power of two).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds an operation.
- in_ready  out  1  stage can accept this cycle.
- in_alu_op  in  2  00 = load/store, 01 = branch, 10 = R-type, 11 = I-type ALU.
- in_funct3  in  3  instruction funct3.
- in_funct7_5  in  1  instruction bit 30.
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b (register value or immediate).
- out_valid  out  1  head entry is presented.
- out_ready  in  1  ALU/execute consumes this cycle.
- out_a  out  DATA_W  head operand a.
- out_b  out  DATA_W  head operand b.
- alu_control_signal  out  4  control code for the ALU.
- out_illegal  out  1  head op is unsupported; its code is 1111.

Behaviour:
- Reset (clk edge with reset=1): count=0, read/write pointers=0. Outputs: out_valid=0, out_illegal=0, alu_control_signal=0000, out_a=0, out_b=0. in_ready is forced to 0 while reset is high.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = !reset & (count < DEPTH), computed from registered count only; it has no combinational path from out_ready.
  - out_valid = (count != 0).
- Decode happens at push; the FIFO stores the code and the illegal bit alongside the operands.
  - alu_op 00 -> 0000 (add).
  - alu_op 01 -> 1000 (sub).
  - alu_op 10 (R-type): funct3 000 gives 0000 if funct7_5=0, else 1000. funct3 100 -> 0100 (xor). 110 -> 0110 (or). 111 -> 0111 (and).
  - alu_op 11 (I-type): funct3 000 -> 0000 (funct7_5 ignored). 100 -> 0100. 110 -> 0110. 111 -> 0111.
  - Any other combination (sll/slt/sltu/srl/sra, funct3 001/010/011/101): code 1111, illegal=1. The ALU returns 0 for 1111. The entry is still queued and issued in order.
- Latency: an op pushed at edge N is visible at the outputs after edge N when the FIFO was empty. Otherwise it appears behind the older entries.
- Head outputs: driven from the FIFO storage at the read pointer. They are held stable while out_valid=1 and out_ready=0.
- Counter update:
  - push only: count+1.
  - pop only: count-1.
  - push & pop in the same cycle (count between 1 and DEPTH-1): count unchanged, both pointers advance.
  - Full (count=DEPTH): in_ready=0, so no push.
  - Empty: out_valid=0, so out_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Outputs when empty: alu_control_signal, out_a, out_b and out_illegal show the stale head entry. Consumers must qualify them with out_valid.
- Reset mid-operation: all queued entries are discarded and nothing is issued after reset.
- Operands are passed unmodified; no arithmetic is done here.

Optional Feature:
- Macro: ALU_CTRL_ISSUE_PERF_EN.
- When defined, add output issue_count (32 bits) and output illegal_count (16 bits).
  - issue_count increments on every pop.
  - illegal_count increments on every pop with out_illegal=1.
  - Both counters saturate at all-ones, not wrap, and clear on reset.
- When undefined, neither port nor counter exists, and the behaviour above is unchanged.

Test Plan:
- Reset with in_valid=1 -> in_ready=0 and out_valid=0. The first cycle after reset has in_ready=1 and count=0.
- Push R-type funct3=000, funct7_5=1, a=10, b=3, out_ready=1 -> one edge later out_valid=1, code 1000, out_a=10, out_b=3. The entry pops the following edge.
- Push xor (R, 100), or (I, 110), and (R, 111) back-to-back with out_ready=0 -> in_ready drops after 2 pushes. Then raise out_ready -> codes 0100, 0110, 0111 in order, no loss.
- Push R-type funct3=001 (sll) -> code 1111, out_illegal=1, issued in order between two legal adds (0000).
- Full FIFO, in_valid=1 held, out_ready=1 for one cycle -> exactly one pop, and one push on the next edge. The held op is accepted exactly once.
- Reset asserted with 2 entries queued -> out_valid=0 after the edge. With ALU_CTRL_ISSUE_PERF_EN, after 5 pops including 1 illegal: issue_count=5, illegal_count=1.
